// File: rtl/calc_pkg.sv
// calc_pkg: operator codes and FSM encoding shared by the
// sequential calculator and its divider step.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_divider_step.sv
// seq_divider_step: one restoring-division iteration.
// Shifts the next dividend bit into the remainder and subtracts if it fits.
module seq_divider_step
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_div};

    // keep the difference only when no borrow, set the quotient bit
    always_comb begin
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        o_rem = w_shift[WIDTH-1:0];
        if (!w_diff[WIDTH]) begin
            o_rem    = w_diff[WIDTH-1:0];
            o_quo[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle add/sub/mul/div with start/busy/done.
// Define SEQ_CALC_SIGNED_EN for two's-complement operands and results.
module seq_calculator
    import calc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_selOperator,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic             o_div_by_zero
);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_overflow;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_op_add;
    logic             w_op_sub;
    logic             w_op_mul;
    logic             w_op_div;
    logic             w_b_zero;
    logic             w_run_mul;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_fin_lo;
    logic [WIDTH-1:0] w_fin_hi;
    logic             w_fin_ovf;

    assign w_op_add  = (i_selOperator == OP_ADD);
    assign w_op_sub  = (i_selOperator == OP_SUB);
    assign w_op_mul  = (i_selOperator == OP_MUL);
    assign w_op_div  = (i_selOperator == OP_DIV);
    assign w_b_zero  = (i_b == '0);
    assign w_accept  = (r_state == ST_IDLE) && i_start;
    assign w_last    = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));
    assign w_run_mul = (r_op == OP_MUL);

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

`ifdef SEQ_CALC_SIGNED_EN
    logic r_sa;
    logic r_sb;
    logic r_min_neg1;
    logic w_min_neg1;

    // carry into the MSB differs from carry out on signed overflow
    assign w_add_ovf = w_sum[WIDTH] ^ (i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ w_sum[WIDTH-1]);
    assign w_sub_ovf = w_dif[WIDTH] ^ (i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ w_dif[WIDTH-1]);
    assign w_opa = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_opb = i_b[WIDTH-1] ? -i_b : i_b;
    assign w_min_neg1 = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
`else
    assign w_add_ovf = w_sum[WIDTH];
    assign w_sub_ovf = w_dif[WIDTH];
    assign w_opa = i_a;
    assign w_opb = i_b;
`endif

    // shift-add multiply step: conditionally add multiplicand, shift right
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    seq_divider_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem (r_hi),
        .i_quo (r_lo),
        .i_div (r_b),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    assign w_step_hi = w_run_mul ? w_mul_hi : w_div_rem;
    assign w_step_lo = w_run_mul ? w_mul_lo : w_div_quo;

`ifdef SEQ_CALC_SIGNED_EN
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;

    assign w_neg      = r_sa ^ r_sb;
    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_fix = w_neg ? -w_prod : w_prod;

    // sign fix-up of the magnitude result on the final step
    always_comb begin
        w_fin_lo  = w_prod_fix[WIDTH-1:0];
        w_fin_hi  = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fin_ovf = (w_fin_hi != {WIDTH{w_fin_lo[WIDTH-1]}});
        if (!w_run_mul) begin
            w_fin_lo  = w_neg ? -w_step_lo : w_step_lo;
            w_fin_hi  = r_sa ? -w_step_hi : w_step_hi;
            w_fin_ovf = r_min_neg1;
        end
    end

    // operand sign capture for the fix-up
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_min_neg1 <= 1'b0;
        end else if (w_accept) begin
            r_sa       <= i_a[WIDTH-1];
            r_sb       <= i_b[WIDTH-1];
            r_min_neg1 <= w_min_neg1;
        end
    end
`else
    // final-step results are the raw accumulators
    always_comb begin
        w_fin_lo  = w_step_lo;
        w_fin_hi  = w_step_hi;
        w_fin_ovf = w_run_mul && (w_step_hi != '0);
    end
`endif

    // state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state: single-cycle ops skip RUN
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (w_op_mul || (w_op_div && !w_b_zero)) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // operand latch, iteration datapath and result registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt         <= '0;
            r_op          <= OP_ADD;
            r_a           <= '0;
            r_b           <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_result      <= '0;
            r_result_hi   <= '0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_op          <= i_selOperator;
            r_a           <= w_opa;
            r_b           <= w_opb;
            r_hi          <= '0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
            unique case (1'b1)
                w_op_add: begin
                    r_result    <= w_sum[WIDTH-1:0];
                    r_result_hi <= '0;
                    r_overflow  <= w_add_ovf;
                end
                w_op_sub: begin
                    r_result    <= w_dif[WIDTH-1:0];
                    r_result_hi <= '0;
                    r_overflow  <= w_sub_ovf;
                end
                w_op_mul: begin
                    r_lo  <= w_opb;
                    r_cnt <= CNT_W'(WIDTH);
                end
                w_op_div: begin
                    if (w_b_zero) begin
                        r_result      <= '0;
                        r_result_hi   <= '0;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_lo  <= w_opa;
                        r_cnt <= CNT_W'(WIDTH);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end else if (r_state == ST_RUN) begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_result    <= w_fin_lo;
                r_result_hi <= w_fin_hi;
                r_overflow  <= w_fin_ovf;
            end
        end
    end

    assign o_result      = r_result;
    assign o_result_hi   = r_result_hi;
    assign o_overflow    = r_overflow;
    assign o_div_by_zero = r_div_by_zero;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed vectors for seq_calculator (WIDTH=8),
// including ignored start, mid-operation reset and latency checks.
module tb_seq_calculator;

    localparam int W = 8;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [1:0]   i_selOperator;
    logic [W-1:0] o_result;
    logic [W-1:0] o_result_hi;
    logic         o_busy;
    logic         o_done;
    logic         o_overflow;
    logic         o_div_by_zero;

    int n_total = 0;
    int n_bad   = 0;

    always #5 i_clk = ~i_clk;

    seq_calculator #(
        .WIDTH (W)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_selOperator (i_selOperator),
        .o_result      (o_result),
        .o_result_hi   (o_result_hi),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_div_by_zero (o_div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // start edge, then scramble inputs to show they are not re-sampled
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
        @(negedge i_clk);
        i_a = a;
        i_b = b;
        i_selOperator = op;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_a = ~a;
        i_b = ~b;
        i_selOperator = ~op;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (lat < 40) begin
            @(negedge i_clk);
            lat++;
            if (o_busy) busy_n++;
            if (o_done) break;
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op,
                          input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                          input logic e_ovf, input logic e_dbz, input int e_lat);
        int lat;
        int busy_n;
        issue(a, b, op);
        wait_done(lat, busy_n);
        check({tag, ".lat"}, lat, e_lat);
        check({tag, ".busy"}, busy_n, e_lat);
        check({tag, ".lo"}, o_result, e_lo);
        check({tag, ".hi"}, o_result_hi, e_hi);
        check({tag, ".ovf"}, o_overflow, e_ovf);
        check({tag, ".dbz"}, o_div_by_zero, e_dbz);
        @(negedge i_clk);
        check({tag, ".pulse"}, {o_done, o_busy}, 0);
        check({tag, ".hold"}, o_result, e_lo);
    endtask

    initial begin
        int lat;
        int dones;
        i_reset_n = 1'b0;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        i_selOperator = ADD;
        #2;
        check("rst.lo", o_result, 0);
        check("rst.hi", o_result_hi, 0);
        check("rst.ctl", {o_busy, o_done, o_overflow, o_div_by_zero}, 0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

`ifdef SEQ_CALC_SIGNED_EN
        run_op("s_div_m7_2", 8'hF9, 8'h02, DIV, 8'hFD, 8'hFF, 1'b0, 1'b0, 9);
        run_op("s_div_7_m2", 8'h07, 8'hFE, DIV, 8'hFD, 8'h01, 1'b0, 1'b0, 9);
        run_op("s_div_min", 8'h80, 8'hFF, DIV, 8'h80, 8'h00, 1'b1, 1'b0, 9);
        run_op("s_add_ovf", 8'd100, 8'd100, ADD, 8'hC8, 8'h00, 1'b1, 1'b0, 1);
        run_op("s_sub_ovf", 8'h80, 8'h01, SUB, 8'h7F, 8'h00, 1'b1, 1'b0, 1);
        run_op("s_sub_ok", 8'hFB, 8'h03, SUB, 8'hF8, 8'h00, 1'b0, 1'b0, 1);
        run_op("s_mul_neg", 8'hFD, 8'h05, MUL, 8'hF1, 8'hFF, 1'b0, 1'b0, 9);
        run_op("s_mul_ovf", 8'd100, 8'd2, MUL, 8'hC8, 8'h00, 1'b1, 1'b0, 9);
        run_op("s_div0", 8'd9, 8'd0, DIV, 8'd0, 8'd0, 1'b0, 1'b1, 1);
`else
        run_op("add_carry", 8'd200, 8'd100, ADD, 8'd44, 8'd0, 1'b1, 1'b0, 1);
        run_op("sub_borrow", 8'd5, 8'd7, SUB, 8'd254, 8'd0, 1'b1, 1'b0, 1);
        run_op("add_plain", 8'd3, 8'd4, ADD, 8'd7, 8'd0, 1'b0, 1'b0, 1);
        run_op("add_wrap", 8'd255, 8'd1, ADD, 8'd0, 8'd0, 1'b1, 1'b0, 1);
        run_op("sub_plain", 8'd7, 8'd5, SUB, 8'd2, 8'd0, 1'b0, 1'b0, 1);
        run_op("mul_20_15", 8'd20, 8'd15, MUL, 8'd44, 8'd1, 1'b1, 1'b0, 9);
        run_op("mul_max", 8'd255, 8'd255, MUL, 8'h01, 8'hFE, 1'b1, 1'b0, 9);
        run_op("mul_zero", 8'd13, 8'd0, MUL, 8'd0, 8'd0, 1'b0, 1'b0, 9);
        run_op("div_200_7", 8'd200, 8'd7, DIV, 8'd28, 8'd4, 1'b0, 1'b0, 9);
        run_op("div_small", 8'd7, 8'd200, DIV, 8'd0, 8'd7, 1'b0, 1'b0, 9);
        run_op("div_by_1", 8'd255, 8'd1, DIV, 8'd255, 8'd0, 1'b0, 1'b0, 9);
        run_op("div0", 8'd9, 8'd0, DIV, 8'd0, 8'd0, 1'b0, 1'b1, 1);
`endif

        issue(8'd3, 8'd4, MUL);
        lat = 0;
        dones = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (k == 2) begin
                i_start = 1'b1;
                i_a = 8'd9;
                i_b = 8'd9;
                i_selOperator = ADD;
            end
            if (k == 3) i_start = 1'b0;
            if (o_done) begin
                dones++;
                if (lat == 0) lat = k;
            end
        end
        check("ign.dones", dones, 1);
        check("ign.lat", lat, 9);
        check("ign.lo", o_result, 12);
        check("ign.hi", o_result_hi, 0);

        issue(8'd200, 8'd7, DIV);
        repeat (4) @(negedge i_clk);
        check("abort.busy", o_busy, 1);
        i_reset_n = 1'b0;
        #1;
        check("abort.lo", o_result, 0);
        check("abort.hi", o_result_hi, 0);
        check("abort.ctl", {o_busy, o_done, o_overflow, o_div_by_zero}, 0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_done) dones++;
        end
        check("abort.nodone", dones, 0);
        run_op("post_rst", 8'd1, 8'd1, ADD, 8'd2, 8'd0, 1'b0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational calculator.
- Operations: add, sub, mul and div on WIDTH-bit operands.
- Start/busy/done handshake; full-width results (mul high half, div remainder); status flags.
- Sits between operand registers/switch inputs and the BCD/FND display path.
- mul is shift-add over WIDTH cycles; div is restoring over WIDTH cycles.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 4..32).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request; sampled only in IDLE.
- i_a  in  WIDTH  operand A (dividend).
- i_b  in  WIDTH  operand B (divisor).
- i_selOperator  in  2  00 add, 01 sub, 10 mul, 11 div.
- o_result  out  WIDTH  low result: sum, difference, product low half, or quotient.
- o_result_hi  out  WIDTH  high result: mul high half, div remainder, 0 for add/sub.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse; results valid from this cycle on.
- o_overflow  out  1  see arithmetic rules.
- o_div_by_zero  out  1  div requested with i_b == 0.

Behaviour:
- Reset (async, i_reset_n low): state IDLE; all outputs 0; counter 0; operand registers 0.
- Reset mid-operation aborts immediately. No o_done is produced for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE with i_start high: i_a, i_b and i_selOperator are latched. Next state:
  - add/sub: result and flags computed and registered at this edge; go to DONE.
  - div with i_b == 0: o_result=0, o_result_hi=0, o_div_by_zero=1; go to DONE.
  - mul, or div with i_b != 0: clear accumulators, load counter with WIDTH; go to RUN.
- RUN: one shift-add or restoring-subtract step per cycle; counter decrements. When the counter reaches 1, results and flags are registered on that edge and the state goes to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Latency from the i_start sampling edge to o_done high: add/sub/div-by-zero 1 cycle; mul/div WIDTH+1 cycles.
- i_start is ignored in RUN and DONE. No queuing.
- Input changes after the start edge have no effect.
- o_result, o_result_hi and the flags hold their values until the next o_done. Both flags are cleared when a new request is accepted.
- Unsigned arithmetic rules:
  - add: o_overflow = carry out.
  - sub: o_overflow = borrow (a < b); result wraps modulo 2^WIDTH.
  - mul: o_overflow = (o_result_hi != 0).
  - div: o_overflow = 0.
- Back-to-back operation: new i_start accepted in the cycle after DONE, i.e. at most one request every 2 cycles (add/sub).

Optional Feature:
- Macro: SEQ_CALC_SIGNED_EN.
- Defined: operands and results are two's complement.
  - add/sub: o_overflow = signed overflow.
  - mul: signed product; o_overflow when the high half is not the sign extension of the low half.
  - div: operands made magnitude first; quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1: o_result=MIN, o_result_hi=0, o_overflow=1.
  - Latency is unchanged; sign fix-up happens on the final RUN edge.
- Undefined: unsigned only, as above; no sign logic is synthesised.

Decomposition:
- Shared package calc_pkg:
  - operator localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - state encoding ST_IDLE, ST_RUN, ST_DONE.
- One sub-module: seq_divider_step. Combinational restoring-division step taking remainder, quotient and divisor, returning the next remainder and quotient.
- Multiplier step stays inline in seq_calculator.

Test Plan (WIDTH=8):
- add 200+100 -> o_result=44, o_result_hi=0, o_overflow=1; o_done 1 cycle after start. sub 5-7 -> o_result=254, o_overflow=1.
- mul 20*15 -> o_result=44, o_result_hi=1, o_overflow=1; o_done exactly 9 cycles after start; o_busy high for those 9 cycles.
- div 200/7 -> o_result=28, o_result_hi=4, flags 0, 9-cycle latency. div 9/0 -> o_result=0, o_result_hi=0, o_div_by_zero=1, latency 1.
- i_start pulsed with new operands during RUN of mul 3*4 -> ignored; result 12; exactly one o_done.
- i_reset_n low at cycle 4 of a div -> all outputs 0 asynchronously; no o_done; next add 1+1 -> 2.
- SEQ_CALC_SIGNED_EN: -7/2 -> o_result=0xFD, o_result_hi=0xFF; -128/-1 -> o_result=0x80, o_overflow=1; 100+100 -> o_result=0xC8, o_overflow=1.
